// File: rtl/proc_pkg.sv
// Shared definitions for the 4-bit processor front end.
// Holds the phase state encoding, default widths and the opcode field positions.
package proc_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } phase_state_e;

   localparam int          PC_W_DEF         = 12;
   localparam logic [11:0] RESET_VECTOR_DEF = 12'h000;

   localparam int INSTR_HI = 7;
   localparam int INSTR_LO = 4;
   localparam int OPRND_HI = 3;
   localparam int OPRND_LO = 0;

endpackage

// File: rtl/program_counter.sv
// Program counter register with load, increment and hold.
// Arithmetic wraps modulo 2^PC_W.
module program_counter
   import proc_pkg::*;
#(
   parameter int             PC_W         = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(RESET_VECTOR_DEF)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            inc,
   input  logic            load,
   input  logic [PC_W-1:0] load_val,
   output logic [PC_W-1:0] pc
);

   logic [PC_W-1:0] pc_r;

   // PC register: load has priority over increment, otherwise hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r <= RESET_VECTOR;
      end else if (load) begin
         pc_r <= load_val;
      end else if (inc) begin
         pc_r <= pc_r + PC_W'(1);
      end else begin
         pc_r <= pc_r;
      end
   end

   assign pc = pc_r;

endmodule

// File: rtl/fetch_sequencer.sv
// Processor front end: fetch/execute phase FSM, opcode capture and data RAM control.
// The RAM low address byte comes straight from program_byte during EXEC.
module fetch_sequencer
   import proc_pkg::*;
#(
   parameter int             PC_W         = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(RESET_VECTOR_DEF)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run,
   input  logic [7:0]      program_byte,
   output logic [PC_W-1:0] pc_addr,
   output logic [3:0]      instr,
   output logic [3:0]      oprnd,
   output logic            phase,
   input  logic            mem_rd,
   input  logic            mem_wr,
   input  logic            load_pc,
   input  logic [PC_W-1:0] jump_addr,
   input  logic            halt_req,
   output logic            chips,
   output logic            enableRW,
   output logic            halted,
   output logic            illegal
);

   phase_state_e    state_r;
   phase_state_e    state_n_s;
   logic [7:0]      fetch_r;
   logic            illegal_r;
   logic            pc_inc_s;
   logic            pc_load_s;
   logic            fetch_en_s;
   logic            in_exec_s;
   logic [PC_W-1:0] pc_s;

   program_counter #(
      .PC_W         (PC_W),
      .RESET_VECTOR (RESET_VECTOR)
   ) u_pc (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (pc_inc_s),
      .load     (pc_load_s),
      .load_val (jump_addr),
      .pc       (pc_s)
   );

   // Next-state and PC control; halt_req beats load_pc beats increment
   always_comb begin
      state_n_s  = state_r;
      pc_inc_s   = 1'b0;
      pc_load_s  = 1'b0;
      fetch_en_s = 1'b0;
      if (run) begin
         case (state_r)
            FETCH: begin
               fetch_en_s = 1'b1;
               pc_inc_s   = 1'b1;
               state_n_s  = EXEC;
            end
            EXEC: begin
               if (halt_req) begin
                  state_n_s = HALT;
               end else if (load_pc) begin
                  pc_load_s = 1'b1;
                  state_n_s = FETCH;
               end else begin
                  pc_inc_s  = 1'b1;
                  state_n_s = FETCH;
               end
            end
            HALT: begin
               state_n_s = HALT;
            end
            default: begin
               state_n_s = FETCH;
            end
         endcase
      end else begin
         state_n_s = state_r;
      end
   end

   // Phase state and fetch register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= FETCH;
         fetch_r <= 8'h00;
      end else begin
         state_r <= state_n_s;
         if (fetch_en_s) begin
            fetch_r <= program_byte;
         end else begin
            fetch_r <= fetch_r;
         end
      end
   end

   // Conflict flag: one-cycle pulse after a simultaneous read and write request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_r <= 1'b0;
      end else begin
         illegal_r <= run & in_exec_s & mem_rd & mem_wr;
      end
   end

   assign in_exec_s = (state_r == EXEC);

   // Only these two outputs see the decoder requests combinationally
   assign chips    = run & in_exec_s & (mem_rd ^ mem_wr);
   assign enableRW = run & in_exec_s & mem_wr & ~mem_rd;

   assign pc_addr = pc_s;
   assign instr   = fetch_r[INSTR_HI:INSTR_LO];
   assign oprnd   = fetch_r[OPRND_HI:OPRND_LO];
   assign phase   = in_exec_s;
   assign halted  = (state_r == HALT);
   assign illegal = illegal_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: per-cycle vector table through a scoreboard
// queue, plus a hand-written asynchronous reset sequence in the middle of EXEC.
module tb_fetch_sequencer;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic [7:0]  program_byte;
   logic [11:0] pc_addr;
   logic [3:0]  instr;
   logic [3:0]  oprnd;
   logic        phase;
   logic        mem_rd;
   logic        mem_wr;
   logic        load_pc;
   logic [11:0] jump_addr;
   logic        halt_req;
   logic        chips;
   logic        enableRW;
   logic        halted;
   logic        illegal;

   logic [7:0]  rom [4096];

   int n_checks;
   int n_err;

   typedef struct {
      logic        run, rd, wr, ld, hlt;
      logic [11:0] jmp;
      logic [11:0] e_pc;
      logic        e_ph;
      logic [3:0]  e_ins, e_op;
      logic        e_cs, e_rw, e_hl, e_il;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];

   fetch_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .run          (run),
      .program_byte (program_byte),
      .pc_addr      (pc_addr),
      .instr        (instr),
      .oprnd        (oprnd),
      .phase        (phase),
      .mem_rd       (mem_rd),
      .mem_wr       (mem_wr),
      .load_pc      (load_pc),
      .jump_addr    (jump_addr),
      .halt_req     (halt_req),
      .chips        (chips),
      .enableRW     (enableRW),
      .halted       (halted),
      .illegal      (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign program_byte = rom[pc_addr];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(logic r, logic rd, logic wr, logic ld, logic hl,
                               logic [11:0] jmp, logic [11:0] pc, logic ph,
                               logic [3:0] ins, logic [3:0] op,
                               logic cs, logic rw, logic eh, logic il);
      vec_t v;
      v.run = r;  v.rd = rd; v.wr = wr; v.ld = ld; v.hlt = hl; v.jmp = jmp;
      v.e_pc = pc; v.e_ph = ph; v.e_ins = ins; v.e_op = op;
      v.e_cs = cs; v.e_rw = rw; v.e_hl = eh; v.e_il = il;
      return v;
   endfunction

   task automatic chk(string nm, logic [11:0] act, logic [11:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_outputs(string tag, vec_t e);
      chk({tag, " pc_addr"}, pc_addr, e.e_pc);
      chk({tag, " phase"}, {11'd0, phase}, {11'd0, e.e_ph});
      chk({tag, " instr"}, {8'd0, instr}, {8'd0, e.e_ins});
      chk({tag, " oprnd"}, {8'd0, oprnd}, {8'd0, e.e_op});
      chk({tag, " chips"}, {11'd0, chips}, {11'd0, e.e_cs});
      chk({tag, " enableRW"}, {11'd0, enableRW}, {11'd0, e.e_rw});
      chk({tag, " halted"}, {11'd0, halted}, {11'd0, e.e_hl});
      chk({tag, " illegal"}, {11'd0, illegal}, {11'd0, e.e_il});
   endtask

   task automatic drive(vec_t v);
      run = v.run; mem_rd = v.rd; mem_wr = v.wr;
      load_pc = v.ld; halt_req = v.hlt; jump_addr = v.jmp;
   endtask

   initial begin
      vec_t e;
      n_checks = 0;
      n_err = 0;
      for (int i = 0; i < 4096; i++) rom[i] = 8'(i) ^ 8'hC3;
      rom[12'h000] = 8'h3A;
      rom[12'h001] = 8'h55;
      rom[12'h002] = 8'h12;
      rom[12'h004] = 8'h9C;
      rom[12'h7F0] = 8'h4E;
      rom[12'hFFE] = 8'hB1;
      rom[12'hFFF] = 8'h77;

      //          run rd  wr  ld  hlt jmp      pc       ph   ins   op    cs   rw   hl   il
      vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,12'h000,12'h000,1'b0,4'h0,4'h0,1'b0,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,12'h000,12'h001,1'b1,4'h3,4'hA,1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,12'h000,12'h002,1'b0,4'h3,4'hA,1'b0,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b1,1'b1,1'b1,1'b0,1'b0,12'h000,12'h003,1'b1,4'h1,4'h2,1'b0,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,12'h000,12'h004,1'b0,4'h1,4'h2,1'b0,1'b0,1'b0,1'b1));
      // run low for five clocks while sitting in EXEC
      vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,12'h000,12'h005,1'b1,4'h9,4'hC,1'b0,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b1,1'b0,1'b1,1'b0,12'h123,12'h005,1'b1,4'h9,4'hC,1'b0,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,12'h000,12'h005,1'b1,4'h9,4'hC,1'b0,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,1'b0,12'h000,12'h005,1'b1,4'h9,4'hC,1'b0,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,12'h000,12'h005,1'b1,4'h9,4'hC,1'b0,1'b0,1'b0,1'b0));
      // jump to 7F0 with a read, then jump to FFE to exercise the wrap
      vecs.push_back(mk(1'b1,1'b1,1'b0,1'b1,1'b0,12'h7F0,12'h005,1'b1,4'h9,4'hC,1'b1,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,12'h000,12'h7F0,1'b0,4'h9,4'hC,1'b0,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,1'b0,12'hFFE,12'h7F1,1'b1,4'h4,4'hE,1'b0,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,12'h000,12'hFFE,1'b0,4'h4,4'hE,1'b0,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,12'h000,12'hFFF,1'b1,4'hB,4'h1,1'b0,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,12'h000,12'h000,1'b0,4'hB,4'h1,1'b0,1'b0,1'b0,1'b0));
      // halt_req and load_pc together: halt wins, pc stays at 001
      vecs.push_back(mk(1'b1,1'b0,1'b1,1'b1,1'b1,12'h7F0,12'h001,1'b1,4'h3,4'hA,1'b1,1'b1,1'b0,1'b0));
      for (int k = 0; k < 10; k++) begin
         vecs.push_back(mk(1'b1, 1'(k % 2), 1'b1, 1'b1, 1'(k % 3 == 0), 12'h7F0,
                           12'h001, 1'b0, 4'h3, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0));
      end

      rst_n = 1'b0;
      drive(mk(1'b1,1'b0,1'b0,1'b0,1'b0,12'h000,12'h000,1'b0,4'h0,4'h0,1'b0,1'b0,1'b0,1'b0));
      @(negedge clk);
      @(negedge clk);
      #2;
      chk_outputs("reset", mk(1'b1,1'b0,1'b0,1'b0,1'b0,12'h000,12'h000,1'b0,4'h0,4'h0,1'b0,1'b0,1'b0,1'b0));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst_n = 1'b1;
         drive(vecs[i]);
         exp_q.push_back(vecs[i]);
         #2;
         e = exp_q.pop_front();
         chk_outputs($sformatf("row%0d", i), e);
         if (i == 1) chk("ram_addr", {oprnd, program_byte}, 12'hA55);
      end

      // Asynchronous reset dropped between edges while a write is in progress
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      chk("rst_halt_pc", pc_addr, 12'h000);
      chk("rst_halted", {11'd0, halted}, 12'h000);
      @(negedge clk);
      rst_n = 1'b1;
      drive(mk(1'b1,1'b0,1'b0,1'b0,1'b0,12'h000,12'h000,1'b0,4'h0,4'h0,1'b0,1'b0,1'b0,1'b0));
      @(negedge clk);
      mem_wr = 1'b1;
      #2;
      chk("async_pre_chips", {11'd0, chips}, 12'h001);
      chk("async_pre_pc", pc_addr, 12'h001);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_chips", {11'd0, chips}, 12'h000);
      chk("async_enableRW", {11'd0, enableRW}, 12'h000);
      chk("async_pc", pc_addr, 12'h000);
      chk("async_phase", {11'd0, phase}, 12'h000);
      @(negedge clk);
      rst_n = 1'b1;
      mem_wr = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
